// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for a one-hot select mux.
// Define RR_SEL_ARBITER_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module rr_sel_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       gnt_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       timeout_o
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
        $error("rr_sel_arbiter: NUM_REQ and MAX_HOLD must both be >= 2");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        ptr, ptr_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic [PW-1:0]        idx_n;
    logic                 valid_n;
    logic                 found;
    logic [PW-1:0]        win;
    logic                 load;
    logic                 forced;
    logic                 release_now;
    int unsigned          pos;

    // Rotating search: first set request at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && req_i[PW'(pos)]) begin
                found = 1'b1;
                win   = PW'(pos);
            end
        end
    end

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold;

    // Forced release only when nothing else would release this edge.
    assign forced = (state == GRANT) && (hold == HW'(MAX_HOLD - 1)) &&
                    !done_i && req_i[gnt_idx_o];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= forced;
            if (load || state_n == IDLE) hold <= '0;
            else                         hold <= hold + 1'b1;
        end
    end
`else
    assign forced    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign release_now = done_i || !req_i[gnt_idx_o] || forced;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt_o;
        idx_n   = gnt_idx_o;
        valid_n = gnt_valid_o;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (found) load = 1'b1;
            end
            GRANT: begin
                if (release_now) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = GRANT;
            gnt_n   = ONE << win;
            idx_n   = win;
            valid_n = 1'b1;
            ptr_n   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            gnt_o       <= gnt_n;
            gnt_idx_o   <= idx_n;
            gnt_valid_o <= valid_n;
        end
    end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that turns a vector of request lines into a registered one-hot grant vector and feeds the `sel_i` input of the downstream one-hot select mux. A grant is held until the owner signals completion or withdraws its request. The arbiter then rotates priority, so every requester is served within `NUM_REQ` grants. The grant vector is guaranteed one-hot or all-zero, which is the only select encoding the mux stage is defined for.

## Interface
- `NUM_REQ`, default 4: number of requesters; width of `req_i` / `gnt_o`; must be ≥ 2.
- `MAX_HOLD`, default 16: maximum grant length in cycles when the timeout feature is compiled in; must be ≥ 2.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req_i`, input, `NUM_REQ`: request lines, level-sensitive; bit i = requester i.
- `done_i`, input, 1: owner completion; releases the current grant; ignored when no grant is active.
- `gnt_o`, output, `NUM_REQ`: registered one-hot grant; all-zero when idle; drives the mux `sel_i`.
- `gnt_valid_o`, output, 1: high iff `gnt_o` is non-zero.
- `gnt_idx_o`, output, `$clog2(NUM_REQ)`: binary index of the granted bit; 0 when idle.
- `timeout_o`, output, 1: one-cycle pulse on a forced release.

## Operation
- **State**
  - FSM states IDLE and GRANT.
  - Priority pointer `ptr` of width `$clog2(NUM_REQ)`.
  - Hold counter, present only with the macro.
- **Arbitration**
  - Search `req_i` starting at index `ptr` and moving upward, wrapping from `NUM_REQ-1` to 0.
  - The first set bit wins.
  - On each grant, `ptr` becomes `(winner+1) mod NUM_REQ`. The last winner therefore has lowest priority next time.
- **IDLE**
  - If `req_i` is non-zero, arbitrate, load `gnt_o` with the winner and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, release condition**
  - Release occurs when `done_i` = 1, or the granted requester's `req_i` bit = 0, or a timeout fires (macro builds only).
- **GRANT, on release**
  - Re-arbitrate on the same edge, masking nothing.
  - If any request remains, `gnt_o` moves directly to the new winner with no idle gap.
  - If no request remains, `gnt_o` = 0 and the FSM goes to IDLE.
  - The same requester can win again only if it is the sole requester.
- **GRANT, no release**: `gnt_o` holds. Changes on non-granted `req_i` bits have no effect.
- **Outputs**
  - `gnt_o`, `gnt_valid_o` and `gnt_idx_o` are all registered and update together.
  - `gnt_o` is never multi-hot.
- **Reset**
  - Reset may be asserted at any time, including mid-grant.
  - It immediately sets `gnt_o` = 0, `gnt_valid_o` = 0, `gnt_idx_o` = 0, `timeout_o` = 0, `ptr` = 0, state = IDLE and hold counter = 0.

## Timing
- **Latency**
  - A request sampled at edge k produces the grant visible after edge k (1 cycle).
  - Release sampled at edge k produces a new grant, or idle, after edge k.
- **Simultaneous events**
  - `done_i` and a dropped request in the same cycle count as a single release.
  - A timeout coinciding with `done_i` is a normal release, and `timeout_o` stays 0.
- **Back-to-back**: with continuous requests and `done_i` high every cycle, the grant advances one requester per cycle.
- **Reset release**: the first edge after `reset_n` deasserts samples `req_i` normally.

## Configuration
- **Macro**: `RR_SEL_ARBITER_TIMEOUT_EN`.
- **Defined**
  - The hold counter clears to 0 on every new grant and increments each cycle in GRANT.
  - If the counter equals `MAX_HOLD-1` at an edge with no other release, a forced release occurs at that edge.
  - The forced release re-arbitrates as above and sets `timeout_o` = 1 for one cycle.
  - A grant therefore lasts at most `MAX_HOLD` cycles.
- **Undefined**
  - No counter is synthesized and `timeout_o` is tied to 0.
  - A grant is held indefinitely until `done_i` or the request drops.

## Test plan
- **Reset**: hold `reset_n` = 0 with `req_i` = 4'b1111 → `gnt_o` = 4'b0000, `gnt_valid_o` = 0, `gnt_idx_o` = 0, `timeout_o` = 0.
- **Single requester**: `req_i` = 4'b0001 → next edge `gnt_o` = 4'b0001, `gnt_idx_o` = 0. Pulse `done_i` with `req_i` = 0 → next edge `gnt_o` = 4'b0000.
- **Rotation**: `req_i` = 4'b1111 held, `done_i` = 1 every cycle → `gnt_o` sequence 0001, 0010, 0100, 1000, 0001.
- **Pointer wrap**: grant index 1 then release (`ptr` = 2), then `req_i` = 4'b0011 → `gnt_o` = 4'b0001.
- **Timeout** (macro defined, `MAX_HOLD` = 4): `req_i` = 4'b0110, `done_i` = 0 → `gnt_o` = 0010 for 4 cycles, `timeout_o` pulses once, `gnt_o` = 0100 next. Without the macro → `gnt_o` = 0010 indefinitely and `timeout_o` = 0.
- **Async reset mid-grant**: assert `reset_n` = 0 between edges during a grant of 4'b0100 → `gnt_o` = 0 immediately without a clock edge. After release with `req_i` = 4'b1100 → `gnt_o` = 4'b0100, showing `ptr` restarted at 0.
